// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular FIFO of 81-bit fetch packets.
// Latency: an entry enqueued at edge N is presented to decode in cycle N+1; there is no bypass.
// Backpressure: fq_stall whenever the registered count is full; decode_stall holds the head entry in place.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_valid,
  input  logic                         fetch_error,
  input  logic [30:0]                  fetch_addr,
  input  logic [31:0]                  fetch_insn,
  input  logic [15:0]                  fetch_bptag,
  input  logic                         fetch_bptaken,
  output logic                         fq_stall,
  output logic                         fetch_de_valid,
  output logic                         fetch_de_error,
  output logic [30:0]                  fetch_de_addr,
  output logic [31:0]                  fetch_de_insn,
  output logic [15:0]                  fetch_de_bptag,
  output logic                         fetch_de_bptaken,
  input  logic                         decode_stall,
  input  logic                         rob_flush,
  output logic [$clog2(DEPTH+1)-1:0]   fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic        error;
    logic [30:0] addr;
    logic [31:0] insn;
    logic [15:0] bptag;
    logic        bptaken;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            enq, deq;
  entry_t          wr_dat;
  entry_t          rd_dat;

  // Handshake qualification: full and flush both block enqueue; flush also hides the head.
  always_comb begin
    fq_stall       = (count_q == CW'(DEPTH));
    fetch_de_valid = (count_q != '0) && !rob_flush;
    enq            = fetch_valid && !fq_stall && !rob_flush;
    deq            = fetch_de_valid && !decode_stall;
    wr_dat         = '{error: fetch_error, addr: fetch_addr, insn: fetch_insn,
                       bptag: fetch_bptag, bptaken: fetch_bptaken};
  end

  // Pointer and occupancy next-state; flush clears everything and overrides enq/deq.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= wr_dat;
  end

  // Head entry drives decode directly from storage.
  always_comb begin
    rd_dat           = mem_q[head_q];
    fetch_de_error   = rd_dat.error;
    fetch_de_addr    = rd_dat.addr;
    fetch_de_insn    = rd_dat.insn;
    fetch_de_bptag   = rd_dat.bptag;
    fetch_de_bptaken = rd_dat.bptaken;
    fq_count         = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        fetch_valid, fetch_error, fetch_bptaken;
  logic [30:0] fetch_addr;
  logic [31:0] fetch_insn;
  logic [15:0] fetch_bptag;
  logic        fq_stall, fetch_de_valid, fetch_de_error, fetch_de_bptaken;
  logic [30:0] fetch_de_addr;
  logic [31:0] fetch_de_insn;
  logic [15:0] fetch_de_bptag;
  logic        decode_stall, rob_flush;
  logic [2:0]  fq_count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_error(fetch_error), .fetch_addr(fetch_addr),
    .fetch_insn(fetch_insn), .fetch_bptag(fetch_bptag), .fetch_bptaken(fetch_bptaken),
    .fq_stall(fq_stall), .fetch_de_valid(fetch_de_valid), .fetch_de_error(fetch_de_error),
    .fetch_de_addr(fetch_de_addr), .fetch_de_insn(fetch_de_insn),
    .fetch_de_bptag(fetch_de_bptag), .fetch_de_bptaken(fetch_de_bptaken),
    .decode_stall(decode_stall), .rob_flush(rob_flush), .fq_count(fq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [80:0] sb[$];

  // Expected packet: side fields derived from the insn word so every field varies.
  function automatic logic [80:0] mk(input logic [30:0] a, input logic [31:0] i);
    return {i[0], a, i, i[15:0] ^ 16'hA5A5, i[1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every dequeue handshake pops the scoreboard and compares the full packet.
  initial begin
    logic [80:0] exp_e, act_e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && fetch_de_valid === 1'b1 && decode_stall === 1'b0) begin
        act_e = {fetch_de_error, fetch_de_addr, fetch_de_insn, fetch_de_bptag, fetch_de_bptaken};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL deq_unexpected act=%0h exp=none t=%0t", act_e, $time);
        end else begin
          exp_e = sb.pop_front();
          if (act_e !== exp_e) begin
            errors++;
            $display("FAIL deq_data act=%0h exp=%0h t=%0t", act_e, exp_e, $time);
          end
        end
      end
    end
  end

  // One cycle: drive inputs, predict acceptance, check state at negedge, advance model.
  task automatic step(input bit fv, input logic [30:0] a, input logic [31:0] i,
                      input bit ds, input bit fl);
    bit exp_valid, enq, deq;
    fetch_valid   = fv;
    fetch_addr    = a;
    fetch_insn    = i;
    fetch_error   = i[0];
    fetch_bptag   = i[15:0] ^ 16'hA5A5;
    fetch_bptaken = i[1];
    decode_stall  = ds;
    rob_flush     = fl;
    exp_valid = (mcount != 0) && !fl;
    enq       = fv && (mcount != DEPTH) && !fl;
    deq       = exp_valid && !ds;
    if (fl) sb.delete();
    if (enq) sb.push_back(mk(a, i));
    @(negedge clk);
    check("count", 32'(fq_count), mcount);
    check("stall", 32'(fq_stall), 32'(mcount == DEPTH));
    check("de_valid", 32'(fetch_de_valid), 32'(exp_valid));
    if (fl) mcount = 0;
    else    mcount = mcount + int'(enq) - int'(deq);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    fetch_valid = 0; fetch_error = 0; fetch_addr = '0; fetch_insn = '0;
    fetch_bptag = '0; fetch_bptaken = 0; decode_stall = 0; rob_flush = 0;
    #2;
    check("rst_count", 32'(fq_count), 0);
    check("rst_stall", 32'(fq_stall), 0);
    check("rst_valid", 32'(fetch_de_valid), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill to full under decode stall; 0x108 must be refused, head held at 0x100.
    for (int k = 0; k < 5; k++) begin
      step(1, 31'h100 + 31'(2*k), 32'hA000_0000 + 32'(k), 1, 0);
      check("hold_addr", 32'(fetch_de_addr), 32'h100);
    end
    check("full_count", 32'(fq_count), 4);
    check("full_stall", 32'(fq_stall), 1);

    // Drain in order 0x100..0x106, then empty.
    for (int k = 0; k < 4; k++) step(0, '0, '0, 0, 0);
    check("drain_count", 32'(fq_count), 0);
    check("drain_valid", 32'(fetch_de_valid), 0);

    // Full plus dequeue: count drops to 3, new insn not stored.
    for (int k = 0; k < 4; k++) step(1, 31'h200 + 31'(2*k), 32'hB000_0010 + 32'(k), 1, 0);
    step(1, 31'h2FE, 32'hDEAD_BEEF, 0, 0);
    check("fpd_count", 32'(fq_count), 3);
    for (int k = 0; k < 3; k++) step(0, '0, '0, 0, 0);

    // Steady state: one in, one out every cycle, one-cycle latency.
    for (int k = 0; k < 6; k++) begin
      step(1, 31'h300 + 31'(2*k), 32'hC000_0100 + 32'(k * 7), 0, 0);
      check("ss_insn", fetch_de_insn, 32'hC000_0100 + 32'(k * 7));
      check("ss_count", 32'(fq_count), 1);
    end
    step(0, '0, '0, 0, 0);

    // Flush with three entries plus a same-cycle fetch.
    for (int k = 0; k < 3; k++) step(1, 31'h400 + 31'(2*k), 32'hD000_0000 + 32'(k), 1, 0);
    step(1, 31'h4FE, 32'hD0D0_D0D0, 1, 1);
    check("flush_count", 32'(fq_count), 0);
    check("flush_valid", 32'(fetch_de_valid), 0);
    step(0, '0, '0, 0, 0);

    // Pointer wrap: three fill/drain rounds, ordering checked by the scoreboard.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++)
        step(1, 31'h500 + 31'(r*16 + 2*k), 32'hE000_0000 + 32'(r*16 + k), (k < 3), 0);
      for (int k = 0; k < 4; k++) step(0, '0, '0, 0, 0);
    end

    // Asynchronous reset mid-cycle with two entries.
    step(1, 31'h600, 32'hF000_0001, 1, 0);
    step(1, 31'h602, 32'hF000_0002, 1, 0);
    check("pre_rst_count", 32'(fq_count), 2);
    fetch_valid = 0;
    #3;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(fq_count), 0);
    check("arst_valid", 32'(fetch_de_valid), 0);
    check("arst_stall", 32'(fq_stall), 0);
    sb.delete();
    mcount = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    step(1, 31'h700, 32'h1234_5678, 1, 0);
    check("post_rst_addr", 32'(fetch_de_addr), 32'h700);
    step(0, '0, '0, 0, 0);
    step(0, '0, '0, 0, 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
